wb_simple_master: RTL and testbench
===================================

WB_SIMPLE_MASTER -- requirements
Module: wb_simple_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in clock cycles, range 1..65535.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the block's only clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have cmd_valid_i in 1 / cmd_ready_o out 1: command handshake.
REQ-005 SHALL have cmd_we_i in 1, cmd_adr_i in 32, cmd_dat_i in 32, cmd_sel_i in 4: write flag, byte address, write data and byte lanes.
REQ-006 SHALL have rsp_valid_o out 1 / rsp_ready_i in 1: response handshake.
REQ-007 SHALL have rsp_dat_o out 32 (read data) and rsp_err_o out 1 (timeout flag).
REQ-008 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32: the Wishbone classic initiator outputs.
REQ-009 SHALL have wbm_ack_i in 1 and wbm_dat_i in 32: the responder's acknowledge and read data.
REQ-010 SHALL have busy_o out 1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, BUS and RESP.
REQ-012 SHALL drive cmd_ready_o=1 only in IDLE.
- A handshake latches the cmd_* fields and moves to BUS.
REQ-013 In BUS, SHALL hold wbm_cyc_o=wbm_stb_o=1 with adr/dat/sel/we stable.
- They are asserted in the cycle after the command handshake.
REQ-014 SHALL ignore wbm_ack_i unless in BUS.
REQ-015 On wbm_ack_i=1 in BUS, SHALL behave as follows on the next cycle:
- deassert cyc/stb;
- capture rsp_dat_o = wbm_dat_i for reads, 0 for writes;
- set rsp_err_o=0;
- enter RESP.
REQ-016 In RESP, SHALL hold rsp_valid_o=1 with stable data until rsp_ready_i=1, then return to IDLE.
- cmd_ready_o rises one cycle later; commands are never accepted in the same cycle as a response.
REQ-017 Latency: with ack in the first BUS cycle, rsp_valid_o SHALL rise 2 cycles after the command handshake.
REQ-018 SHALL have at most one transaction outstanding; there is no pipelining or burst.
REQ-019 wbm_dat_o SHALL be 0 for reads.

Reset
REQ-020 Asserting wb_rst_n_i SHALL, asynchronously:
- force IDLE;
- set all outputs to 0, except cmd_ready_o which is 1 once reset is released.
- This applies even mid-BUS: cyc/stb drop immediately and the pending response is discarded.
REQ-021 Deasserting reset SHALL take effect synchronously at the next rising edge.

Configuration
REQ-022 With WB_SIMPLE_MASTER_TIMEOUT_EN defined, the watchdog SHALL be active:
- it counts BUS cycles from 1;
- when the count reaches TIMEOUT_CYCLES with no ack, the next cycle deasserts cyc/stb, sets rsp_err_o=1 and rsp_dat_o=0, and enters RESP;
- if ack coincides with the expiry cycle, ack wins (rsp_err_o=0);
- the counter clears on entering BUS.
REQ-023 Without WB_SIMPLE_MASTER_TIMEOUT_EN, BUS SHALL wait for ack indefinitely, rsp_err_o SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-024 Package wb_simple_master_pkg SHALL hold the state enum, WB_ADR_W=32, WB_DAT_W=32 and WB_SEL_W=4.
REQ-025 The watchdog SHALL be a sub-module wb_ack_watchdog (inputs: start, ack; output: expired), instantiated only under the macro.

Verification
REQ-026 Write: cmd adr=0x3000_0000, dat=0x0000_00A5, sel=0xF, we=1; slave acks in the first BUS cycle -> one cyc/stb cycle with those values, then rsp_valid_o=1, rsp_dat_o=0, rsp_err_o=0, 2 cycles after the handshake.
REQ-027 Read: slave acks after 3 wait cycles with dat=0x0000_005A -> cyc/stb held 4 cycles, then rsp_dat_o=0x0000_005A.
REQ-028 Backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_dat_o stable, cmd_ready_o=0 throughout; cmd_ready_o=1 the cycle after the response handshake.
REQ-029 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> cyc/stb high for exactly 4 cycles, then rsp_err_o=1, rsp_dat_o=0; ack in cycle 4 -> rsp_err_o=0.
REQ-030 Reset mid-BUS: pull wb_rst_n_i low -> cyc/stb=0 without waiting for a clock edge; after release, cmd_ready_o=1 and no stale rsp_valid_o.
REQ-031 Stray ack: wbm_ack_i pulsed in IDLE and in RESP -> no change of state or outputs.

Source files
------------

// File: rtl/wb_simple_master_pkg.sv
// Shared types and bus widths for the single-outstanding Wishbone classic initiator.
package wb_simple_master_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_simple_master_watchdog.sv
// Ack watchdog: a down-counter armed when a command enters BUS; flags expiry on the
// TIMEOUT_CYCLES-th BUS cycle that has no ack. Only built with WB_SIMPLE_MASTER_TIMEOUT_EN.
module wb_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic expired
);

  logic [15:0] r_remain;
  logic        r_armed;

  // r_remain holds the BUS cycles left after the current one, so the first BUS cycle counts as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed  <= 1'b0;
      r_remain <= '0;
    end else if (start) begin
      r_armed  <= 1'b1;
      r_remain <= 16'(TIMEOUT_CYCLES - 1);
    end else if (r_armed) begin
      if (ack || expired) begin
        r_armed <= 1'b0;
      end else begin
        r_remain <= r_remain - 16'd1;
      end
    end
  end

  assign expired = r_armed && (r_remain == 16'd0);

endmodule

// File: rtl/wb_simple_master.sv
// Command/response to Wishbone classic initiator, one transaction at a time.
// Define WB_SIMPLE_MASTER_TIMEOUT_EN to enable the ack watchdog (wb_ack_watchdog).
//
// state   | meaning
// IDLE    | cmd_ready_o high, waiting for a command handshake
// BUS     | cyc/stb asserted, waiting for ack (or watchdog expiry)
// RESP    | rsp_valid_o high, holding the response until rsp_ready_i
module wb_simple_master
  import wb_simple_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_DAT_W-1:0] r_rsp_dat;
  logic                w_cmd_fire;
  logic                w_bus_ack;
  logic                w_expired;
  logic                w_bus_tmo;

  // Gated by reset so the ready flag is low while reset is held and high once released.
  assign cmd_ready_o = (r_state == ST_IDLE) && wb_rst_n_i;
  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign w_bus_ack   = (r_state == ST_BUS) && wbm_ack_i;
  assign w_bus_tmo   = (r_state == ST_BUS) && w_expired && !wbm_ack_i;

`ifdef WB_SIMPLE_MASTER_TIMEOUT_EN
  logic r_rsp_err;

  wb_ack_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .start  (w_cmd_fire),
    .ack    (w_bus_ack),
    .expired(w_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_rsp_err <= 1'b0;
    end else if (w_bus_ack) begin
      r_rsp_err <= 1'b0;
    end else if (w_bus_tmo) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err_o = r_rsp_err;
`else
  assign w_expired = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_fire)              w_state_nxt = ST_BUS;
      ST_BUS:  if (w_bus_ack || w_bus_tmo)  w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready_i)             w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
    end else if (w_cmd_fire) begin
      r_we  <= cmd_we_i;
      r_adr <= cmd_adr_i;
      r_dat <= cmd_we_i ? cmd_dat_i : '0;
      r_sel <= cmd_sel_i;
    end
  end

  // Ack takes priority over a coincident watchdog expiry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_rsp_dat <= '0;
    end else if (w_bus_ack) begin
      r_rsp_dat <= r_we ? '0 : wbm_dat_i;
    end else if (w_bus_tmo) begin
      r_rsp_dat <= '0;
    end
  end

  assign wbm_cyc_o   = (r_state == ST_BUS);
  assign wbm_stb_o   = (r_state == ST_BUS);
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_dat_o   = r_rsp_dat;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_simple_master.sv
// Self-checking bench for wb_simple_master: vector table with a response scoreboard,
// plus hand sequences for reset, mid-BUS reset and stray acks.
module tb_wb_simple_master;

  localparam int T = 4;
`ifdef WB_SIMPLE_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_dly;
    logic [31:0] rd;
    int          bp;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic        clk, rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  rsp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] last_dat;

  wb_simple_master #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_sel_i  (cmd_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    rsp_t        e, got;
    int          guard, lat, cyc_cnt, exp_cyc;
    bit          tmo, bus_ok, bp_ok;
    logic [31:0] exp_wdat;

    tmo      = TO_EN && (v.ack_dly + 1 > T);
    exp_cyc  = tmo ? T : v.ack_dly + 1;
    e.dat    = (tmo || v.we) ? 32'h0 : v.rd;
    e.err    = tmo;
    exp_wdat = v.we ? v.dat : 32'h0;

    guard = 0;
    while (!cmd_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d cmd_ready_idle", idx), cmd_ready_o, 1);
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    cmd_valid_i = 1'b1;
    sb.push_back(e);

    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~v.we;
    cmd_adr_i   = ~v.adr;
    cmd_dat_i   = ~v.dat;
    cmd_sel_i   = ~v.sel;
    lat     = 1;
    cyc_cnt = 0;
    bus_ok  = 1'b1;
    while (!rsp_valid_o && lat < 200) begin
      if (wbm_cyc_o && wbm_stb_o) begin
        cyc_cnt++;
        if (wbm_adr_o !== v.adr || wbm_sel_o !== v.sel || wbm_we_o !== v.we ||
            wbm_dat_o !== exp_wdat || !busy_o || cmd_ready_o)
          bus_ok = 1'b0;
        wbm_ack_i = (cyc_cnt == v.ack_dly + 1);
        wbm_dat_i = v.rd;
      end else begin
        bus_ok = 1'b0;
      end
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'h0BAD_F00D;
      lat++;
    end
    check($sformatf("v%0d bus_fields", idx), bus_ok, 1);
    check($sformatf("v%0d cyc_cycles", idx), cyc_cnt, exp_cyc);
    check($sformatf("v%0d rsp_latency", idx), lat, exp_cyc + 1);
    check($sformatf("v%0d cyc_dropped", idx), {wbm_cyc_o, wbm_stb_o}, 0);

    // Backpressure, with stray acks that must be ignored in RESP.
    bp_ok = 1'b1;
    for (int k = 0; k < v.bp; k++) begin
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'hFFFF_0000 ^ k;
      if (!rsp_valid_o || rsp_dat_o !== e.dat || rsp_err_o !== e.err || cmd_ready_o || wbm_cyc_o)
        bp_ok = 1'b0;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0;
    check($sformatf("v%0d backpressure_stable", idx), bp_ok, 1);

    rsp_ready_i = 1'b1;
    check($sformatf("v%0d sb_nonempty", idx), sb.size(), 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check($sformatf("v%0d rsp_valid", idx), rsp_valid_o, 1);
      check($sformatf("v%0d rsp_dat", idx), rsp_dat_o, got.dat);
      check($sformatf("v%0d rsp_err", idx), rsp_err_o, got.err);
      last_dat = got.dat;
    end
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check($sformatf("v%0d rsp_valid_cleared", idx), rsp_valid_o, 0);
    check($sformatf("v%0d cmd_ready_after_rsp", idx), cmd_ready_o, 1);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    last_dat    = '0;

    //            we    adr            dat            sel   ack bus-data       bp
    vecs.push_back(vec_t'{1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 0, 32'hFFFF_FFFF, 0});
    vecs.push_back(vec_t'{1'b0, 32'h3000_0004, 32'h1234_5678, 4'hF, 3, 32'h0000_005A, 0});
    vecs.push_back(vec_t'{1'b0, 32'h4000_0010, 32'h0000_0000, 4'h3, 0, 32'hCAFE_BABE, 5});
    vecs.push_back(vec_t'{1'b1, 32'h0000_0ABC, 32'hDEAD_BEEF, 4'h1, 1, 32'h1111_2222, 2});
    vecs.push_back(vec_t'{1'b0, 32'h8000_0000, 32'h0000_0000, 4'hC, 7, 32'h8000_0001, 1});
    vecs.push_back(vec_t'{1'b0, 32'h1234_5670, 32'h0000_0000, 4'hF, 30, 32'h7777_0001, 0});
    if (TO_EN) begin
      vecs.push_back(vec_t'{1'b0, 32'h5555_0000, 32'h0, 4'hF, 255, 32'h9999_9999, 2});
      vecs.push_back(vec_t'{1'b0, 32'h5555_0004, 32'h0, 4'hF, T - 1, 32'h0000_0042, 0});
      vecs.push_back(vec_t'{1'b1, 32'h5555_0008, 32'hA, 4'hF, T - 2, 32'h0000_0043, 0});
    end

    // Reset held: every output low, including cmd_ready_o.
    repeat (3) @(negedge clk);
    check("rst cmd_ready", cmd_ready_o, 0);
    check("rst busy", busy_o, 0);
    check("rst cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
    check("rst rsp_valid", rsp_valid_o, 0);
    check("rst rsp_dat", rsp_dat_o, 0);
    check("rst rsp_err", rsp_err_o, 0);
    check("rst wbm_adr", wbm_adr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst cmd_ready", cmd_ready_o, 1);

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i);

    // Stray ack in IDLE must not start anything or disturb the last response.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hA5A5_A5A5;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    @(negedge clk);
    check("stray_idle busy", busy_o, 0);
    check("stray_idle cyc", wbm_cyc_o, 0);
    check("stray_idle rsp_valid", rsp_valid_o, 0);
    check("stray_idle cmd_ready", cmd_ready_o, 1);
    check("stray_idle rsp_dat", rsp_dat_o, last_dat);

    // Reset mid-BUS: cyc/stb fall without a clock edge, no stale response afterwards.
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h6000_0000;
    cmd_sel_i   = 4'hF;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    check("midbus cyc_before", wbm_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midbus cyc_stb_async", {wbm_cyc_o, wbm_stb_o}, 0);
    check("midbus busy_async", busy_o, 0);
    check("midbus adr_async", wbm_adr_o, 0);
    check("midbus cmd_ready_in_rst", cmd_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midbus cmd_ready_after", cmd_ready_o, 1);
    check("midbus no_stale_rsp", rsp_valid_o, 0);
    check("midbus busy_after", busy_o, 0);
    check("midbus rsp_dat_after", rsp_dat_o, 0);

    // Recovery transaction after the mid-BUS reset.
    run_txn(vec_t'{1'b0, 32'h7000_0000, 32'h0, 4'hF, 1, 32'h0000_0BEE, 0}, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
